// File: rtl/multi_signal_check_pkg.sv
// Shared types and helpers for the multi-channel signal checker.
// Channel FSM encoding, run-counter sizing and saturating increment.
package multi_signal_check_pkg;

  typedef enum logic [1:0] {IDLE, CHECK, SUSPECT, FAIL} ch_state_e;

  // Width needed for a run counter that must be able to hold the threshold itself
  function automatic int run_width(input int thresh);
    return $clog2(thresh + 1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/signal_check_ch.sv
// One checker channel: input capture, masked compare, debounce FSM,
// consecutive-mismatch run counter and saturating mismatch counter.
module signal_check_ch
  import multi_signal_check_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int FAIL_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] signal_in,
  input  logic [WIDTH-1:0] expected,
  input  logic [WIDTH-1:0] mask,
  output logic             match,
  output logic             fail,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int RUN_W = run_width(FAIL_THRESH);

  logic             en_q, en_d;
  logic [WIDTH-1:0] samp_q, samp_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  ch_state_e        state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             match_q, match_d;
  logic             mis;

  always_comb begin
    en_d    = en;
    samp_d  = signal_in;
    exp_d   = expected;
    mask_d  = mask;
    mis     = |((samp_q ^ exp_q) & mask_q);
    state_d = state_q;
    run_d   = run_q;
    err_d   = err_q;
    match_d = en_q & ~mis;

    if (en_q && mis) begin
      err_d = CNT_W'(sat_inc(32'(err_q), CNT_W));
    end

    // FAIL is sticky; every other state re-evaluates from the current compare
    case (state_q)
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        if (!en_q) begin
          state_d = IDLE;
          run_d   = '0;
        end else if (!mis) begin
          state_d = CHECK;
          run_d   = '0;
        end else begin
          run_d   = run_q + 1'b1;
          state_d = (run_d >= RUN_W'(FAIL_THRESH)) ? FAIL : SUSPECT;
        end
      end
    endcase

    // Clear discards this edge's compare entirely; stage-1 capture still proceeds
    if (clear) begin
      state_d = IDLE;
      run_d   = '0;
      err_d   = '0;
      match_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      samp_q  <= '0;
      exp_q   <= '0;
      mask_q  <= '0;
      state_q <= IDLE;
      run_q   <= '0;
      err_q   <= '0;
      match_q <= 1'b0;
    end else begin
      en_q    <= en_d;
      samp_q  <= samp_d;
      exp_q   <= exp_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      run_q   <= run_d;
      err_q   <= err_d;
      match_q <= match_d;
    end
  end

  assign match   = match_q;
  assign fail    = (state_q == FAIL);
  assign err_cnt = err_q;

endmodule

// File: rtl/multi_signal_check.sv
// Passive multi-channel signal monitor: NUM_CH independent checker channels,
// an aggregated fail flag and a selectable mismatch counter readout.
module multi_signal_check
  import multi_signal_check_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 8,
  parameter int FAIL_THRESH = 3,
  parameter int CNT_W       = 16,
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*WIDTH-1:0] signal_in,
  input  logic [NUM_CH*WIDTH-1:0] expected,
  input  logic [NUM_CH*WIDTH-1:0] mask,
  input  logic                    clear,
  input  logic [SEL_W-1:0]        sel,
  output logic [NUM_CH-1:0]       match,
  output logic [NUM_CH-1:0]       fail,
  output logic                    any_fail,
  output logic [CNT_W-1:0]        err_cnt
);

  logic [CNT_W-1:0] cnt_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    signal_check_ch #(
      .WIDTH       (WIDTH),
      .FAIL_THRESH (FAIL_THRESH),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .en        (en[g]),
      .signal_in (signal_in[g*WIDTH +: WIDTH]),
      .expected  (expected[g*WIDTH +: WIDTH]),
      .mask      (mask[g*WIDTH +: WIDTH]),
      .match     (match[g]),
      .fail      (fail[g]),
      .err_cnt   (cnt_arr[g])
    );
  end

  assign any_fail = |fail;

  // Out-of-range selector values read as zero when NUM_CH is not a power of two
  always_comb begin
    err_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) err_cnt = cnt_arr[i];
    end
  end

endmodule
